// File: rtl/ipc_link.sv
// ipc_link: bit-serial IPC command/reply engine emulating the QL 8049 link.
// Receives host bits from zx8302, returns reply bit and busy flag, and
// buffers PS/2 key events in a small FIFO for the keyboard reply.
// Optional feature: define IPC_KEYROW_EN to add the key_matrix port and
// the 0x9 keyboard-row command.
module ipc_link #(
  parameter int unsigned BUSY_CYCLES     = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk_bus,
  input  logic        reset,
  input  logic        ipc_bit_strobe,
  input  logic        ipc_bit,
  output logic        ipc_reply_bit,
  output logic        ipc_busy,
  input  logic        key_strobe,
  input  logic [5:0]  key_code,
  input  logic [2:0]  key_mod,
  output logic        kbd_pending
`ifdef IPC_KEYROW_EN
  ,
  input  logic [63:0] key_matrix
`endif
);

  localparam int unsigned DEPTH  = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned BUSY_W = 8;
  localparam int unsigned BITS_W = 7;
  localparam int unsigned ENT_W  = 9;
  localparam int unsigned REC_W  = 10;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_ARG   = 2'd1,
    S_REPLY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic                busy_q;
  logic [2:0]          nib_q, nib_d;
  logic [1:0]          nib_cnt_q, nib_cnt_d;
  logic [7:0]          sr_q, sr_d;
  logic [3:0]          sr_cnt_q, sr_cnt_d;
  logic                kbd_q, kbd_d;
  logic [3:0]          rec_bit_q, rec_bit_d;
  logic [BITS_W-1:0]   bits_left_q, bits_left_d;
  logic                reply_bit_q, reply_bit_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                lost_q;
  logic                pending_q;

  logic [3:0]          nibble;
  logic                last_nib;
  logic [2:0]          n_snap;
  logic [REC_W-1:0]    rec_word;
  logic                full, push_ok, drop;
  logic                pop, flush, lost_clr;

  assign nibble   = {nib_q, ipc_bit};
  assign last_nib = ipc_bit_strobe && (nib_cnt_q == 2'd3);
  assign n_snap   = (level_q >= LVL_W'(7)) ? 3'd7 : 3'(level_q);
  assign rec_word = {1'b0, mem_q[rd_ptr_q]};
  assign full     = (level_q == LVL_W'(DEPTH));
  assign push_ok  = key_strobe && !full;
  assign drop     = key_strobe && full;
  assign level_d  = flush ? '0 : (level_q + LVL_W'(push_ok) - LVL_W'(pop));
  assign busy_cnt_d = ipc_bit_strobe ? BUSY_W'(BUSY_CYCLES)
                    : ((busy_cnt_q != '0) ? (busy_cnt_q - BUSY_W'(1)) : '0);

  assign ipc_reply_bit = reply_bit_q;
  assign ipc_busy      = busy_q;
  assign kbd_pending   = pending_q;

  // State register
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  // Next-state logic: command decode, argument collection, reply drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CMD: begin
        if (last_nib) begin
          case (nibble)
            4'h1, 4'h8: state_d = S_REPLY;
`ifdef IPC_KEYROW_EN
            4'h9:       state_d = S_ARG;
`endif
            default:    state_d = S_CMD;
          endcase
        end
      end
      S_ARG:   if (last_nib) state_d = S_REPLY;
      S_REPLY: if (ipc_bit_strobe && (bits_left_q == BITS_W'(1))) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  // Datapath next values: nibble shifting, reply loading and serialisation
  always_comb begin
    nib_d       = nib_q;
    nib_cnt_d   = nib_cnt_q;
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    kbd_d       = kbd_q;
    rec_bit_d   = rec_bit_q;
    bits_left_d = bits_left_q;
    reply_bit_d = reply_bit_q;
    pop         = 1'b0;
    flush       = 1'b0;
    lost_clr    = 1'b0;
    if (ipc_bit_strobe) begin
      if (state_q == S_REPLY) begin
        bits_left_d = bits_left_q - BITS_W'(1);
        if (sr_cnt_q != 4'd0) begin
          // header / status / row byte comes from the small shift register
          reply_bit_d = sr_q[7];
          sr_d        = {sr_q[6:0], 1'b0};
          sr_cnt_d    = sr_cnt_q - 4'd1;
          lost_clr    = kbd_q && (sr_cnt_q == 4'd1);
        end else begin
          // key records are read straight from the FIFO head
          reply_bit_d = rec_word[4'd9 - rec_bit_q];
          if (rec_bit_q == 4'd9) begin
            pop       = 1'b1;
            rec_bit_d = 4'd0;
          end else begin
            rec_bit_d = rec_bit_q + 4'd1;
          end
        end
      end else begin
        nib_d     = nibble[2:0];
        nib_cnt_d = nib_cnt_q + 2'd1;
        if (nib_cnt_q == 2'd3) begin
          if (state_q == S_ARG) begin
`ifdef IPC_KEYROW_EN
            sr_d        = key_matrix[{nibble[2:0], 3'b000} +: 8];
            sr_cnt_d    = 4'd8;
            kbd_d       = 1'b0;
            bits_left_d = BITS_W'(8);
`endif
          end else begin
            case (nibble)
              4'h0: flush = 1'b1;
              4'h1: begin
                sr_d        = {7'b0, (level_q != '0)};
                sr_cnt_d    = 4'd8;
                kbd_d       = 1'b0;
                bits_left_d = BITS_W'(8);
              end
              4'h8: begin
                sr_d        = {lost_q, n_snap, 4'b0000};
                sr_cnt_d    = 4'd4;
                kbd_d       = 1'b1;
                rec_bit_d   = 4'd0;
                bits_left_d = BITS_W'(4) + (BITS_W'(n_snap) * BITS_W'(10));
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Datapath, busy counter, FIFO pointers and lost flag registers
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      busy_cnt_q  <= '0;
      busy_q      <= 1'b0;
      nib_q       <= '0;
      nib_cnt_q   <= '0;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      kbd_q       <= 1'b0;
      rec_bit_q   <= '0;
      bits_left_q <= '0;
      reply_bit_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      lost_q      <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      busy_q      <= (busy_cnt_d != '0);
      nib_q       <= nib_d;
      nib_cnt_q   <= nib_cnt_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      kbd_q       <= kbd_d;
      rec_bit_q   <= rec_bit_d;
      bits_left_q <= bits_left_d;
      reply_bit_q <= reply_bit_d;
      level_q     <= level_d;
      pending_q   <= (level_d != '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        lost_q   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (drop)          lost_q <= 1'b1;
        else if (lost_clr) lost_q <= 1'b0;
      end
    end
  end

  // Key FIFO storage
  always_ff @(posedge clk_bus) begin
    if (push_ok) mem_q[wr_ptr_q] <= {key_mod, key_code};
  end

endmodule

// File: tb/tb_ipc_link.sv
// Scoreboard bench for ipc_link: driver runs a queue-based protocol model and
// pushes expected reply bits; a monitor pops and compares on every strobe.
module tb_ipc_link;

  localparam int BUSY  = 8;
  localparam int DEPTH = 8;

  logic       clk_bus = 1'b0;
  logic       reset = 1'b1;
  logic       stb = 1'b0, bitv = 1'b0, kstb = 1'b0;
  logic [5:0] kcode = '0;
  logic [2:0] kmod = '0;
  logic       ipc_reply_bit, ipc_busy, kbd_pending;
`ifdef IPC_KEYROW_EN
  logic [63:0] kmat = '0;
`endif

  always #5 clk_bus = ~clk_bus;

  ipc_link dut (
    .clk_bus        (clk_bus),
    .reset          (reset),
    .ipc_bit_strobe (stb),
    .ipc_bit        (bitv),
    .ipc_reply_bit  (ipc_reply_bit),
    .ipc_busy       (ipc_busy),
    .key_strobe     (kstb),
    .key_code       (kcode),
    .key_mod        (kmod),
    .kbd_pending    (kbd_pending)
`ifdef IPC_KEYROW_EN
    ,
    .key_matrix     (kmat)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic rbit; logic is_reply; } exp_t;
  exp_t       exp_q[$];
  logic       got_q[$];

  // reference model state
  logic [8:0] kq[$];
  logic       rq[$];
  logic [1:0] fq[$];      // [0]=pop head after this bit, [1]=clear lost after this bit
  logic       m_lost = 1'b0;
  int         m_mode = 0; // 0 command, 1 argument, 2 reply
  logic [3:0] m_nib = '0;
  int         m_cnt = 0;
  logic       m_reply = 1'b0;
  int         m_busy = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // pack n captured reply bits starting at index first
  task automatic chk_bits(input string name, input int first, input int n, input logic [31:0] exp);
    logic [31:0] act;
    act = '0;
    for (int i = 0; i < n; i++)
      act = {act[30:0], (first + i < got_q.size()) ? got_q[first + i] : 1'bx};
    chk_vec(name, act, exp);
  endtask

  function automatic void model_reset();
    kq.delete(); rq.delete(); fq.delete();
    m_lost = 1'b0; m_mode = 0; m_nib = '0; m_cnt = 0; m_reply = 1'b0; m_busy = 0;
  endfunction

  function automatic void add_bits(input logic [9:0] v, input int n, input logic [1:0] last_flags);
    for (int i = n - 1; i >= 0; i--) begin
      rq.push_back(v[i]);
      fq.push_back((i == 0) ? last_flags : 2'b00);
    end
  endfunction

  // one clock edge of protocol behaviour
  function automatic void model_step(input logic s, input logic b, input logic ks, input logic [8:0] ke);
    logic       full;
    logic       was_reply;
    logic [1:0] f;
    int         n;
    full = (kq.size() == DEPTH);
    was_reply = 1'b0;
    if (s) begin
      if (m_mode == 2) begin
        was_reply = 1'b1;
        m_reply = rq.pop_front();
        f = fq.pop_front();
        if (f[0]) void'(kq.pop_front());
        if (f[1]) m_lost = 1'b0;
        if (rq.size() == 0) m_mode = 0;
      end else begin
        m_nib = {m_nib[2:0], b};
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0;
          if (m_mode == 1) begin
`ifdef IPC_KEYROW_EN
            add_bits(10'(kmat[int'(m_nib[2:0]) * 8 +: 8]), 8, 2'b00);
`endif
            m_mode = 2;
          end else begin
            case (m_nib)
              4'h0: begin kq.delete(); m_lost = 1'b0; end
              4'h1: begin add_bits(10'(kq.size() != 0), 8, 2'b00); m_mode = 2; end
              4'h8: begin
                n = (kq.size() > 7) ? 7 : kq.size();
                add_bits({6'b0, m_lost, 3'(n)}, 4, 2'b10);
                for (int i = 0; i < n; i++) add_bits({1'b0, kq[i]}, 10, 2'b01);
                m_mode = 2;
              end
`ifdef IPC_KEYROW_EN
              4'h9: m_mode = 1;
`endif
              default: ;
            endcase
          end
        end
      end
      exp_q.push_back('{rbit: m_reply, is_reply: was_reply});
    end
    if (ks) begin
      if (full) m_lost = 1'b1;
      else      kq.push_back(ke);
    end
    m_busy = s ? BUSY : ((m_busy > 0) ? m_busy - 1 : 0);
  endfunction

  // monitor: compares outputs just after each active edge
  initial begin
    logic s;
    exp_t e;
    forever begin
      @(posedge clk_bus);
      s = stb;
      #1;
      if (reset) begin
        chk("rst_reply", ipc_reply_bit, 1'b0);
        chk("rst_busy", ipc_busy, 1'b0);
        chk("rst_pending", kbd_pending, 1'b0);
      end else begin
        chk("busy", ipc_busy, m_busy != 0);
        chk("pending", kbd_pending, kq.size() != 0);
        if (s) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_underflow: strobe seen with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("reply_bit", ipc_reply_bit, e.rbit);
            if (e.is_reply) got_q.push_back(ipc_reply_bit);
          end
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic b, input logic ks, input logic [8:0] ke);
    stb = s; bitv = b; kstb = ks; {kmod, kcode} = ke;
    model_step(s, b, ks, ke);
    @(negedge clk_bus);
    stb = 1'b0; kstb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic send_nib(input logic [3:0] v, input int gap);
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b1, v[i], 1'b0, 9'h0);
      idle(gap);
    end
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 9'h0);
      idle(gap);
    end
  endtask

  task automatic push_key(input logic [8:0] ke);
    cyc(1'b0, 1'b0, 1'b1, ke);
  endtask

  task automatic do_reset();
    stb = 1'b0; kstb = 1'b0; reset = 1'b1;
    model_reset(); exp_q.delete(); got_q.delete();
    repeat (2) @(negedge clk_bus);
    reset = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s, b, ks;
    do_reset();

    // 1: status reply with empty and non-empty FIFO, busy window
    send_nib(4'h1, 9);
    got_q.delete();
    strobes(8, 3);
    chk_bits("status_empty", 0, 8, 32'h00);
    push_key(9'h1AB);
    send_nib(4'h1, 0);
    got_q.delete();
    strobes(8, 10);
    chk_bits("status_pending", 0, 8, 32'h01);

    // 2: two-key keyboard reply
    do_reset();
    push_key({3'b100, 6'h2A});
    push_key({3'b000, 6'h15});
    send_nib(4'h8, 1);
    got_q.delete();
    strobes(24, 0);
    chk_bits("kbd_two_keys", 0, 24, 32'h24A815);
    idle(3);

    // 3: overflow sets lost, n capped at 7, second read clears lost
    do_reset();
    for (int i = 0; i < 9; i++) push_key(9'(i * 37 + 5));
    send_nib(4'h8, 0);
    got_q.delete();
    strobes(74, 0);
    chk_bits("ovf_header", 0, 4, 32'hF);
    send_nib(4'h8, 0);
    got_q.delete();
    strobes(14, 0);
    chk_bits("after_ovf_header", 0, 4, 32'h1);

    // 4a: push coincident with pop of a full FIFO is dropped
    do_reset();
    for (int i = 0; i < 8; i++) push_key(9'(i * 11 + 3));
    send_nib(4'h8, 0);
    strobes(13, 0);
    cyc(1'b1, 1'b0, 1'b1, 9'h155);
    strobes(60, 0);
    send_nib(4'h8, 0);
    got_q.delete();
    strobes(14, 0);
    chk_bits("full_pop_push_header", 0, 4, 32'h9);
    // 4b: push coincident with pop at level 3 is kept
    send_nib(4'h0, 0);
    for (int i = 0; i < 3; i++) push_key(9'(i + 40));
    send_nib(4'h8, 0);
    strobes(13, 0);
    cyc(1'b1, 1'b0, 1'b1, 9'h0C7);
    strobes(20, 0);
    send_nib(4'h8, 0);
    got_q.delete();
    strobes(14, 0);
    chk_bits("lvl3_push_header", 0, 4, 32'h1);
    chk_bits("lvl3_push_record", 4, 10, 32'h0C7);

    // 5: reset in the middle of a 44-bit keyboard reply
    do_reset();
    for (int i = 0; i < 4; i++) push_key(9'(i * 101 + 7));
    send_nib(4'h8, 0);
    strobes(30, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_reply", ipc_reply_bit, 1'b0);
    chk("async_rst_busy", ipc_busy, 1'b0);
    chk("async_rst_pending", kbd_pending, 1'b0);
    do_reset();
    send_nib(4'h1, 0);
    got_q.delete();
    strobes(8, 0);
    chk_bits("status_after_rst", 0, 8, 32'h00);

    // 6: keyboard row command (or its absence)
    do_reset();
`ifdef IPC_KEYROW_EN
    kmat = 64'h0;
    kmat[23:16] = 8'hA5;
    send_nib(4'h9, 0);
    send_nib(4'h2, 0);
    got_q.delete();
    strobes(8, 0);
    chk_bits("keyrow", 0, 8, 32'hA5);
`else
    send_nib(4'h9, 0);
    send_nib(4'h1, 0);
    got_q.delete();
    strobes(8, 0);
    chk_bits("no_keyrow_status", 0, 8, 32'h00);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      s  = ($urandom_range(0, 2) == 0);
      b  = 1'($urandom_range(0, 1));
      ks = ($urandom_range(0, 5) == 0) && (!s || m_mode == 2);
      if ($urandom_range(0, 1499) == 0) do_reset();
`ifdef IPC_KEYROW_EN
      if ($urandom_range(0, 63) == 0) kmat = {$urandom, $urandom};
`endif
      cyc(s, b, ks, 9'($urandom));
    end

    idle(12);
    chk_vec("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
